// File: rtl/gates4_pkg.sv
// gates4_pkg: shared FSM state type and default sizing for the gate checker
package gates4_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_NUM_SAMPLES = 216;
endpackage

// File: rtl/gates4_ref.sv
// gates4_ref: reference 4-input AND/OR/XOR responses
module gates4_ref (
  input  logic [3:0] din,
  output logic       out_and,
  output logic       out_or,
  output logic       out_xor
);
  assign out_and = &din;
  assign out_or  = |din;
  assign out_xor = ^din;
endmodule

// File: rtl/gates4_checker.sv
// gates4_checker: compares DUT gate responses against a reference and tallies mismatches per run
module gates4_checker
  import gates4_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sample_valid,
  input  logic [3:0]       din,
  input  logic             dut_and,
  input  logic             dut_or,
  input  logic             dut_xor,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_total,
  output logic [CNT_W-1:0] err_and,
  output logic [CNT_W-1:0] err_or,
  output logic [CNT_W-1:0] err_xor,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_valid
);
  state_t state, state_n;
  logic exp_and, exp_or, exp_xor, mis_and, mis_or, mis_xor, mis_any, acc, clr, last;
  gates4_ref u_ref (.din(din), .out_and(exp_and), .out_or(exp_or), .out_xor(exp_xor));
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != '1) ? v + CNT_W'(1) : v;
  endfunction
  assign mis_and = dut_and != exp_and;
  assign mis_or  = dut_or != exp_or;
  assign mis_xor = dut_xor != exp_xor;
  assign mis_any = mis_and | mis_or | mis_xor;
  assign acc     = state == RUN && sample_valid;
  assign clr     = state != RUN && start;
  assign last    = sample_cnt == CNT_W'(NUM_SAMPLES - 1);
  always_comb state_n = (acc && last) ? DONE : clr ? RUN : state;
  // Decodes of registered state and counters only, so no input reaches these outputs.
  assign busy = state == RUN;
  assign done = state == DONE;
  assign pass = done && err_total == '0;
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      state           <= reset ? IDLE : RUN;
      sample_cnt      <= '0;
      err_total       <= '0;
      err_and         <= '0;
      err_or          <= '0;
      err_xor         <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
        err_total  <= sat_inc(err_total, mis_any);
        err_and    <= sat_inc(err_and, mis_and);
        err_or     <= sat_inc(err_or, mis_or);
        err_xor    <= sat_inc(err_xor, mis_xor);
        if (mis_any && !first_err_valid) begin
          first_err_idx   <= sample_cnt;
          first_err_valid <= 1'b1;
        end
      end
    end
  end
endmodule
